// File: rtl/poly_eval_arbiter_if.sv
// Requester/consumer handshake bundle for poly_eval_arbiter.
// master = requester and consumer side, slave = arbiter side.
interface poly_eval_arbiter_if;
   logic        req0_valid;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [7:0]  rsp_data;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/poly_eval_arbiter.sv
// Round-robin front end that shares one quadratic evaluator between two requesters,
// replaying its Go/DataIn load sequence and returning the tagged 8-bit result.
module poly_eval_arbiter #(
   parameter int unsigned COMPUTE_CYCLES = 5
) (
   input  logic                Clock,
   input  logic                Resetn,
   poly_eval_arbiter_if.slave  bus,
   output logic                EvalGo,
   output logic [7:0]          EvalDataIn,
   input  logic [7:0]          EvalResult,
   output logic                busy
);

   localparam int unsigned CntW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

   typedef enum logic [2:0] {StIdle, StLoad, StCompute, StCapture, StResp} state_e;

   state_e          state_q, state_d;
   logic [2:0]      phase_q, phase_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     data_q, data_d;
   logic            id_q, id_d;
   logic            last_q, last_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic            grant0, grant1;

   // Ties go to the requester that was not served last.
   assign grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
   assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= StIdle;
         phase_q    <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         id_q       <= 1'b0;
         last_q     <= 1'b1;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         id_q       <= id_d;
         last_q     <= last_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      cnt_d          = cnt_q;
      data_d         = data_q;
      id_d           = id_q;
      last_d         = last_q;
      rsp_data_d     = rsp_data_q;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.rsp_valid  = 1'b0;
      EvalGo         = 1'b0;
      EvalDataIn     = '0;

      unique case (state_q)
         StIdle: begin
            bus.req0_ready = grant0 & Resetn;
            bus.req1_ready = grant1 & Resetn;
            if (grant0 | grant1) begin
               data_d  = grant1 ? bus.req1_data : bus.req0_data;
               id_d    = grant1;
               last_d  = grant1;
               phase_d = '0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            // Even phase presses Go, odd phase releases it; operand held across the pair.
            EvalGo = ~phase_q[0];
            unique case (phase_q[2:1])
               2'd0: EvalDataIn = data_q[31:24];
               2'd1: EvalDataIn = data_q[23:16];
               2'd2: EvalDataIn = data_q[15:8];
               2'd3: EvalDataIn = data_q[7:0];
               default: EvalDataIn = '0;
            endcase
            phase_d = phase_q + 3'd1;
            if (phase_q == 3'd7) begin
               cnt_d   = '0;
               state_d = StCompute;
            end
         end
         StCompute: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(COMPUTE_CYCLES - 1)) begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            rsp_data_d = EvalResult;
            state_d    = StResp;
         end
         StResp: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.rsp_data = rsp_data_q;
   assign bus.rsp_id   = id_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: doc/poly_eval_arbiter.md
# poly_eval_arbiter

Round-robin scheduler that shares one quadratic evaluator (`part2`: Go/DataIn operand loading, result Ax²+Bx+C on DataResult) between two requesters. It accepts a packed operand set {A,B,C,X} from each requester over a valid/ready handshake. It replays the evaluator's Go-press/Go-release loading sequence, waits out the compute cycles, and returns the 8-bit result tagged with the requester id. It sits between the requester logic and the evaluator instance and is the only driver of the evaluator's Go and DataIn.

## Interface
- COMPUTE_CYCLES, 5, number of evaluator compute states between X-release and result-register update
- Clock  in  1  rising-edge clock, shared with the evaluator
- Resetn  in  1  asynchronous, active-low reset; same net also drives evaluator Resetn (synchronous there)
- req0_valid  in  1  requester 0 has an operand set
- req0_data  in  32  {A[31:24], B[23:16], C[15:8], X[7:0]}
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid / req1_data / req1_ready  same as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns rsp_data
- rsp_data  out  8  (A·X·X + B·X + C) mod 256
- EvalGo  out  1  to evaluator Go
- EvalDataIn  out  8  to evaluator DataIn
- EvalResult  in  8  from evaluator DataResult
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE → LOAD (8 cycles, phase counter 0..7) → COMPUTE (COMPUTE_CYCLES cycles) → CAPTURE (1 cycle) → RESP → IDLE.
- IDLE:
  - Grant = requester with valid. If both are valid, grant the requester not granted last.
  - Last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The granted requester's ready is high combinationally in IDLE. The other requester's ready stays 0.
  - On the accept edge, latch the 32-bit data and the id, update the pointer, and go to LOAD.
- LOAD, phase p:
  - Operand index = p>>1 (A, B, C, X).
  - EvalDataIn = operand.
  - EvalGo = 1 on even p, 0 on odd p. This gives one press cycle and one release cycle per operand, matching the evaluator's LOAD/LOAD_WAIT pairs.
  - EvalDataIn holds the operand for both cycles of the pair.
  - After p=7, go to COMPUTE.
- COMPUTE: EvalGo=0. Count COMPUTE_CYCLES, then go to CAPTURE.
- CAPTURE: EvalResult is valid this cycle. Register rsp_data<=EvalResult and go to RESP.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id stay stable until rsp_ready.
  - On the handshake edge, go to IDLE.
  - No new request is accepted before that edge.
- EvalGo=0 and EvalDataIn=0 in IDLE, CAPTURE and RESP. The evaluator therefore always sits in S_LOAD_A whenever this block is in IDLE.
- Requesters must hold valid and data stable until ready. The arbiter neither checks nor relies on data after the accept edge.
- Arithmetic is performed entirely by the evaluator with 8-bit wrap. This block never modifies the result.

## Timing
- Reset (async assert) sets:
  - state=IDLE, pointer=1
  - rsp_valid=0, rsp_data=0, rsp_id=0
  - EvalGo=0, EvalDataIn=0, busy=0
  - both ready outputs 0 while Resetn is low
- Resetn must stay low across at least one Clock edge so the evaluator's synchronous reset also takes effect.
- Reset mid-operation (any state) abandons the job with no response. The first accept is possible in the first cycle after release.
- Cycle numbering, with accept edge at the end of cycle t:
  - EvalGo press cycles: t+1, t+3, t+5, t+7
  - COMPUTE: cycles t+9..t+13
  - CAPTURE: cycle t+14
  - rsp_valid high from cycle t+15
- Accept-to-response is 15 cycles with default COMPUTE_CYCLES.
- If rsp_ready is high on first assertion, IDLE is reached in t+16. The next accept can then occur in t+16, giving a minimum 16-cycle period per job.
- rsp_ready high while rsp_valid is low is ignored.
- rsp backpressure stalls indefinitely in RESP. busy stays 1 and both ready outputs stay 0.

## Test plan
- Single job, requester 0, A=1 B=2 C=3 X=4 → rsp_valid at t+15, rsp_id=0, rsp_data=27. EvalGo pattern 1,0,1,0,1,0,1,0 over t+1..t+8, with EvalDataIn 1,1,2,2,3,3,4,4.
- Wrap: requester 1 alone, A=3 B=5 C=7 X=10 → rsp_id=1, rsp_data=101 (357 mod 256 via the evaluator's 8-bit steps).
- Contention:
  - Stimulus: both valid continuously from reset; requester 0 carries A=0 B=1 C=0 X=9, requester 1 carries A=0 B=0 C=5 X=0.
  - Required: responses alternate id 0,1,0,1 with data 9,5,9,5. Each ready pulses exactly once per job.
- Backpressure: rsp_ready held low 10 cycles after rsp_valid → rsp_valid, rsp_data and rsp_id stable, busy=1, no ready asserted. On release, one handshake occurs, then IDLE.
- Reset mid-load:
  - Stimulus: drop Resetn during cycle t+5 for 2 edges.
  - Required: all outputs 0 immediately and no response. A following job A=2 B=0 C=1 X=3 returns 19.
